// File: rtl/pindex_pkg.sv
// Shared types and width helpers for the max-pooling index buffer.
package pindex_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } pindex_state_e;

  // Width of a field able to index n items, never narrower than one bit.
  function automatic int max1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Number of decoder strobes that release one frame; 0 selects the depth.
  function automatic int frame_reads(input int rd_per_frame, input int depth);
    return (rd_per_frame == 0) ? depth : rd_per_frame;
  endfunction

endpackage

// File: rtl/pindex_if.sv
// Encoder write / decoder read bundle of the pooling-index buffer.
interface pindex_if #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 21
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              pindex_rd;
  logic [ADDR_W-1:0] pindex_rd_addr;
  logic [DATA_W-1:0] pindex_out;
  logic              pindex_valid;
  logic              full;
  logic              frame_done;
  logic              wr_ovf;
  logic              rd_err;

  modport master (
    output wr_en, wr_data, pindex_rd, pindex_rd_addr,
    input  pindex_out, pindex_valid, full, frame_done, wr_ovf, rd_err
  );

  modport slave (
    input  wr_en, wr_data, pindex_rd, pindex_rd_addr,
    output pindex_out, pindex_valid, full, frame_done, wr_ovf, rd_err
  );
endinterface

// File: rtl/pindex_buffer_mem.sv
// 1W1R synchronous index store with a registered read port; contents are never reset.
module pindex_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/pindex_buffer.sv
// One-frame pooling-index buffer: encoder fills it sequentially, decoder reads it
// at random addresses, and the frame is released after a fixed number of reads.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no frame held, wr_ptr=0, rd_cnt=0; first write starts a frame
// ST_FILL  | frame partially written, writes land at wr_ptr
// ST_FULL  | frame complete, reads legal, writes dropped
module pindex_buffer
  import pindex_pkg::*;
#(
  parameter int H            = 32,
  parameter int W            = 128,
  parameter int FD           = 512,
  parameter int N_PE         = 1,
  parameter int POOL_H       = 2,
  parameter int POOL_W       = 2,
  parameter int RD_PER_FRAME = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  pindex_if.slave  bus
);
  localparam int DEPTH        = H * W * FD / N_PE;
  localparam int PINDEX_WIDTH = max1_clog2(POOL_H * POOL_W);
  localparam int DATA_W       = PINDEX_WIDTH * N_PE;
  localparam int ADDR_WIDTH   = max1_clog2(DEPTH);
  localparam int RD_LIMIT     = frame_reads(RD_PER_FRAME, DEPTH);
  localparam int CNT_W        = max1_clog2(RD_LIMIT);

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      LAST_RD   = CNT_W'(RD_LIMIT - 1);

  pindex_state_e         state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic                  full_q;
  logic                  valid_q;
  logic                  frame_done_q;
  logic                  wr_ovf_q;
  logic                  rd_err_q;
  logic                  out_zero_q;

  logic                  in_full;
  logic                  rd_in_range;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  mem_re;
  logic [DATA_W-1:0]     mem_rdata;

  assign in_full     = (state_q == ST_FULL);
  assign rd_in_range = ({1'b0, bus.pindex_rd_addr} < DEPTH_EXT);
  assign wr_accept   = bus.wr_en && !in_full;
  assign rd_accept   = bus.pindex_rd && in_full;
  assign mem_re      = rd_accept && rd_in_range;

  pindex_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .re_i    (mem_re),
    .raddr_i (bus.pindex_rd_addr),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      wr_ptr_q     <= '0;
      rd_cnt_q     <= '0;
      full_q       <= 1'b0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ovf_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      out_zero_q   <= 1'b1;
    end else begin
      valid_q      <= rd_accept;
      frame_done_q <= 1'b0;
      // The memory read register is not reset, so a zero output is tracked
      // separately: after reset and after an out-of-range read.
      if (rd_accept) begin
        out_zero_q <= !rd_in_range;
      end
      if (bus.wr_en && in_full) begin
        wr_ovf_q <= 1'b1;
      end
      if (bus.pindex_rd && !(in_full && rd_in_range)) begin
        rd_err_q <= 1'b1;
      end

      case (state_q)
        ST_EMPTY: begin
          if (bus.wr_en) begin
            if (DEPTH == 1) begin
              state_q  <= ST_FULL;
              full_q   <= 1'b1;
              wr_ptr_q <= '0;
            end else begin
              state_q  <= ST_FILL;
              wr_ptr_q <= ADDR_WIDTH'(1);
            end
          end
        end
        ST_FILL: begin
          if (bus.wr_en) begin
            if (wr_ptr_q == LAST_ADDR) begin
              state_q  <= ST_FULL;
              full_q   <= 1'b1;
              wr_ptr_q <= '0;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (bus.pindex_rd) begin
            if (rd_cnt_q == LAST_RD) begin
              state_q      <= ST_EMPTY;
              full_q       <= 1'b0;
              frame_done_q <= 1'b1;
              rd_cnt_q     <= '0;
            end else begin
              rd_cnt_q <= rd_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= ST_EMPTY;
          full_q   <= 1'b0;
          wr_ptr_q <= '0;
          rd_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.pindex_out   = out_zero_q ? '0 : mem_rdata;
  assign bus.pindex_valid = valid_q;
  assign bus.full         = full_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.wr_ovf       = wr_ovf_q;
  assign bus.rd_err       = rd_err_q;
endmodule
